// File: rtl/iq_pkg.sv
// Shared parameters and types for the issue-queue entry manager.
// Tags are stored zero-extended to IqTagWidthMax so the entry struct is parameter independent.
package iq_pkg;

    localparam int IqEntryCount   = 4;
    localparam int IqEnqWidth     = 2;
    localparam int IqSelWidth     = 2;
    localparam int IqPayloadWidth = 32;
    localparam int IqTagWidth     = 6;
    localparam int IqTagWidthMax  = 16;

    function automatic int cntWidth(input int entries);
        return $clog2(entries + 1);
    endfunction

    typedef struct packed {
        logic                     vld;
        logic                     srcRdy;
        logic [IqTagWidthMax-1:0] tag;
    } iq_entry_t;

endpackage

// File: rtl/iq_free_picker.sv
// Find-first-N over the free vector: lane i gets the i-th lowest free entry.
// Ready bits come from the free popcount so lane i is ready only if i+1 slots exist.
module iq_free_picker
    import iq_pkg::*;
#(
    parameter int EntryCount = IqEntryCount,
    parameter int EnqWidth   = IqEnqWidth
) (
    input  logic [EntryCount-1:0]               free_i,
    output logic [EnqWidth-1:0][EntryCount-1:0] pick_mask_o,
    output logic [EnqWidth-1:0]                 pick_rdy_o
);

    logic [EntryCount-1:0] remaining;
    int unsigned           freeCount;

    always_comb begin
        remaining   = free_i;
        freeCount   = 0;
        pick_mask_o = '0;
        pick_rdy_o  = '0;
        for (int e = 0; e < EntryCount; e++) begin
            freeCount = freeCount + 32'(free_i[e]);
        end
        for (int i = 0; i < EnqWidth; i++) begin
            // Scanning downward leaves the lowest remaining free index as the final pick.
            for (int e = EntryCount - 1; e >= 0; e--) begin
                if (remaining[e]) begin
                    pick_mask_o[i]    = '0;
                    pick_mask_o[i][e] = 1'b1;
                end
            end
            remaining     = remaining & ~pick_mask_o[i];
            pick_rdy_o[i] = (freeCount > 32'(i));
        end
    end

endmodule

// File: rtl/iq_entry_manager.sv
// Entry state and payload store for one issue queue, feeding the age-matrix selector.
// Allocates dispatch lanes, tracks operand readiness via tag wakeup, muxes picked payloads to issue ports.
module iq_entry_manager
    import iq_pkg::*;
#(
    parameter int EntryCount   = IqEntryCount,
    parameter int EnqWidth     = IqEnqWidth,
    parameter int SelWidth     = IqSelWidth,
    parameter int PayloadWidth = IqPayloadWidth,
    parameter int TagWidth     = IqTagWidth,
    localparam int CntW        = cntWidth(EntryCount)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic [EnqWidth-1:0]                  disp_vld_i,
    output logic [EnqWidth-1:0]                  disp_rdy_o,
    input  logic [EnqWidth-1:0][PayloadWidth-1:0] disp_payload_i,
    input  logic [EnqWidth-1:0][TagWidth-1:0]    disp_tag_i,
    input  logic [EnqWidth-1:0]                  disp_src_rdy_i,
    input  logic                                 wakeup_vld_i,
    input  logic [TagWidth-1:0]                  wakeup_tag_i,
    output logic [EnqWidth-1:0]                  enq_fire_o,
    output logic [EnqWidth-1:0][EntryCount-1:0]  enq_mask_o,
    output logic                                 deq_fire_o,
    output logic [EntryCount-1:0]                deq_mask_o,
    output logic [EntryCount-1:0]                sel_mask_o,
    output logic [EntryCount-1:0]                entry_vld_o,
    input  logic [SelWidth-1:0][EntryCount-1:0]  sel_result_i,
    output logic [SelWidth-1:0]                  issue_vld_o,
    input  logic [SelWidth-1:0]                  issue_rdy_i,
    output logic [SelWidth-1:0][PayloadWidth-1:0] issue_payload_o,
    output logic [CntW-1:0]                      count_o
);

    iq_entry_t [EntryCount-1:0]                entryState_q, entryState_d;
    logic [EntryCount-1:0][PayloadWidth-1:0]   payload_q;
    logic [CntW-1:0]                           count_q, count_d;

    logic [EntryCount-1:0]                     freeVec;
    logic [EnqWidth-1:0][EntryCount-1:0]       pickMask;
    logic [EnqWidth-1:0]                       pickRdy;
    logic [SelWidth-1:0]                       issueFire;
    logic [CntW-1:0]                           enqCnt;
    logic [CntW-1:0]                           issCnt;

    // Only the registered valid vector frees slots; same-cycle dequeues are reusable next cycle.
    always_comb begin
        for (int e = 0; e < EntryCount; e++) begin
            freeVec[e]     = ~entryState_q[e].vld;
            entry_vld_o[e] = entryState_q[e].vld;
            sel_mask_o[e]  = entryState_q[e].vld & entryState_q[e].srcRdy;
        end
    end

    iq_free_picker #(
        .EntryCount (EntryCount),
        .EnqWidth   (EnqWidth)
    ) u_free_picker (
        .free_i      (freeVec),
        .pick_mask_o (pickMask),
        .pick_rdy_o  (pickRdy)
    );

    always_comb begin
        disp_rdy_o = flush_i ? '0 : pickRdy;
        enq_fire_o = disp_vld_i & disp_rdy_o;
        enqCnt     = '0;
        for (int i = 0; i < EnqWidth; i++) begin
            enq_mask_o[i] = enq_fire_o[i] ? pickMask[i] : '0;
            enqCnt        = enqCnt + CntW'(enq_fire_o[i]);
        end
    end

    always_comb begin
        deq_mask_o      = '0;
        issCnt          = '0;
        issue_payload_o = '0;
        for (int k = 0; k < SelWidth; k++) begin
            issue_vld_o[k] = (|sel_result_i[k]) & ~flush_i;
            issueFire[k]   = issue_vld_o[k] & issue_rdy_i[k];
            if (issueFire[k]) begin
                deq_mask_o = deq_mask_o | sel_result_i[k];
            end
            issCnt = issCnt + CntW'(issueFire[k]);
            for (int e = 0; e < EntryCount; e++) begin
                if (sel_result_i[k][e]) begin
                    issue_payload_o[k] = issue_payload_o[k] | payload_q[e];
                end
            end
        end
        deq_fire_o = |deq_mask_o;
    end

    // Wakeup, then dequeue, then allocation; flush overrides everything.
    always_comb begin
        entryState_d = entryState_q;
        for (int e = 0; e < EntryCount; e++) begin
            if (wakeup_vld_i && entryState_q[e].vld &&
                entryState_q[e].tag == IqTagWidthMax'(wakeup_tag_i)) begin
                entryState_d[e].srcRdy = 1'b1;
            end
            if (deq_mask_o[e]) begin
                entryState_d[e].vld    = 1'b0;
                entryState_d[e].srcRdy = 1'b0;
            end
        end
        for (int i = 0; i < EnqWidth; i++) begin
            for (int e = 0; e < EntryCount; e++) begin
                if (enq_mask_o[i][e]) begin
                    entryState_d[e].vld    = 1'b1;
                    entryState_d[e].tag    = IqTagWidthMax'(disp_tag_i[i]);
                    entryState_d[e].srcRdy = disp_src_rdy_i[i] |
                                             (wakeup_vld_i && (disp_tag_i[i] == wakeup_tag_i));
                end
            end
        end
        if (flush_i) begin
            for (int e = 0; e < EntryCount; e++) begin
                entryState_d[e].vld    = 1'b0;
                entryState_d[e].srcRdy = 1'b0;
            end
        end
        count_d = flush_i ? '0 : (count_q + enqCnt - issCnt);
    end

    // Tags are deliberately left out of the reset branch; they are meaningless while vld is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < EntryCount; e++) begin
                entryState_q[e].vld    <= 1'b0;
                entryState_q[e].srcRdy <= 1'b0;
            end
            count_q <= '0;
        end else begin
            entryState_q <= entryState_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < EnqWidth; i++) begin
            for (int e = 0; e < EntryCount; e++) begin
                if (enq_mask_o[i][e]) begin
                    payload_q[e] <= disp_payload_i[i];
                end
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: doc/iq_entry_manager.md
# iq_entry_manager

Entry-state and payload store for one issue-queue instance, directly upstream of the age-matrix selector. Allocates free entries to up to EnqWidth dispatched micro-ops per cycle and tracks per-entry valid and operand-ready state via tag wakeup. Drives the selector's enq/deq/select/valid inputs, consumes its per-port one-hot result masks, and presents the chosen payloads on SelWidth issue ports with valid/ready handshakes.

## Interface
- EntryCount, 4, number of queue entries (≥ EnqWidth)
- EnqWidth, 2, dispatch lanes per cycle
- SelWidth, 2, issue ports per cycle
- PayloadWidth, 32, opaque micro-op payload bits
- TagWidth, 6, wakeup tag width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  invalidate all entries
- disp_vld_i  in  EnqWidth  dispatch request per lane; must be a prefix (lane i valid ⇒ lanes <i valid)
- disp_rdy_o  out  EnqWidth  lane i accepted if set
- disp_payload_i  in  EnqWidth×PayloadWidth  payload per lane
- disp_tag_i  in  EnqWidth×TagWidth  source tag awaited by the entry
- disp_src_rdy_i  in  EnqWidth  operand already available
- wakeup_vld_i  in  1  tag broadcast valid
- wakeup_tag_i  in  TagWidth  broadcast tag
- enq_fire_o  out  EnqWidth  to selector: lane allocates this cycle
- enq_mask_o  out  EnqWidth×EntryCount  to selector: one-hot target entry per lane
- deq_fire_o  out  1  to selector: any entry freed this cycle
- deq_mask_o  out  EntryCount  to selector: OR of freed entries
- sel_mask_o  out  EntryCount  to selector: valid & operand-ready
- entry_vld_o  out  EntryCount  to selector: registered valid vector
- sel_result_i  in  SelWidth×EntryCount  from selector: one-hot0 pick per port, oldest first
- issue_vld_o  out  SelWidth  issue port valid
- issue_rdy_i  in  SelWidth  issue port ready
- issue_payload_o  out  SelWidth×PayloadWidth  payload of picked entry
- count_o  out  clog2(EntryCount+1)  occupied entries (registered)

## Operation
- State per entry: vld, src_rdy, tag, payload. Reset: all vld=0, src_rdy=0; payload/tag not reset.
- Free vector = ~vld (registered only; an entry freed this cycle is not reallocated until next cycle).
- Allocation: lane i takes the i-th lowest-index free entry. disp_rdy_o[i] = ~flush_i & (popcount(free) > i). Lane fires when disp_vld_i[i] & disp_rdy_o[i]; enq_fire_o[i] mirrors that, enq_mask_o[i] is the target one-hot (zero when not firing).
- On fire: vld←1, payload/tag captured, src_rdy ← disp_src_rdy_i | (wakeup_vld_i & wakeup_tag_i==disp_tag_i).
- Wakeup: every valid entry with matching tag sets src_rdy at the edge.
- sel_mask_o = vld & src_rdy. issue_vld_o[k] = |sel_result_i[k] & ~flush_i; issue_payload_o[k] = one-hot mux of payload by sel_result_i[k] (zero if none).
- Issue fire k = issue_vld_o[k] & issue_rdy_i[k]; deq_mask_o = OR of sel_result_i[k] over fired k; deq_fire_o = |deq_mask_o. Fired entries: vld←0, src_rdy←0. Un-acked picks stay valid and are re-presented.
- Flush: highest priority; next-cycle vld=0 for all, count_o=0; enq_fire_o, deq_fire_o, issue_vld_o, disp_rdy_o all 0 that cycle.
- count_o ← count_o + enq fires − issue fires (or 0 on flush); never exceeds EntryCount.
- sel_result_i masks are disjoint across ports (selector guarantee); not re-checked.

## Timing
- Reset values: disp_rdy_o all 1, issue_vld_o 0, enq_fire_o 0, deq_fire_o 0, sel_mask_o 0, entry_vld_o 0, count_o 0.
- Dispatch at edge N → entry_vld_o/sel_mask_o visible in cycle N+1 → earliest issue cycle N+1 (selector is combinational).
- Wakeup in cycle N → issue eligible N+1; no same-cycle bypass.
- Issue handshake combinational on issue_rdy_i; dequeue at same edge; slot reusable from N+1.
- Full: disp_rdy_o all 0 while count_o==EntryCount, even if an issue fires that cycle.
- rst asserted mid-operation: state cleared immediately (asynchronous), in-flight handshakes dropped.

## Structure
- Package iq_pkg: default parameters, count width function, entry-state struct (vld, src_rdy, tag).
- Sub-module iq_free_picker: combinational find-first-N over free vector, outputs EnqWidth one-hot masks and popcount-gated ready bits.
- Top holds entry registers, wakeup compare, payload muxes, counter.

## Test plan
- Reset, dispatch 2 lanes src_rdy=1 into empty 4-entry queue → enq_mask {0001,0010}, next cycle sel_mask_o=0011, count_o=2.
- Fill to 4, assert disp_vld_i=11 → disp_rdy_o=00; issue entry 0 with issue_rdy=1 → disp_rdy_o=01 next cycle, enq_mask_o[0]=0001.
- Dispatch tag 5 src_rdy=0; wakeup tag 5 one cycle later → sel_mask bit set cycle after wakeup; wakeup tag 5 same cycle as dispatch → ready on first valid cycle.
- Both ports picked, issue_rdy_i=01 → only port-0 entry dequeued, deq_mask_o equals sel_result_i[0]; port-1 entry re-presented next cycle.
- flush_i with 3 valid entries plus dispatch and issue pending → no fires, entry_vld_o=0 and count_o=0 next cycle.
- rst pulse mid-burst (between edges) → all outputs return to reset values immediately.
